// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multichannel PWM block.
//   - Default parameter values: PWM_NUM_CH, PWM_CNT_W, PWM_PRESC_W.
//   - cnt_dir_e: counter direction. Only used by the center-aligned build.
//   - sel_w(): width of a channel-select field. Never returns less than 1 bit.
// ----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_NUM_CH  = 16;
  localparam int PWM_CNT_W   = 8;
  localparam int PWM_PRESC_W = 8;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_e;

  // A single-channel build would otherwise need a zero-width select port.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// ----------------------------------------------------------------------------
// pwm_channel
// One PWM output. It holds the double-buffered duty value and does the
// compare and the output select.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   cnt          shared period counter value
//   load         period boundary: active duty takes the pending duty
//   wr           duty write strobe for this channel
//   wr_data      duty value for the write
//   en_out       0 forces the output low
//   en_pwm       0 (with en_out=1) forces the output high
//   pwm_out      registered channel output
// ----------------------------------------------------------------------------
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             load,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             en_out,
  input  logic             en_pwm,
  output logic             pwm_out
);

  logic [CNT_W-1:0] pending_duty;
  logic [CNT_W-1:0] active_duty;
  logic             pwm_raw;

  // Edge-aligned compare. Duty 0 never matches. Duty MAX always matches,
  // because the edge-aligned count stops at MAX-1.
  assign pwm_raw = (cnt < active_duty);

  // NOTE: these duty registers are a handful of flops, not a RAM. They are
  //       reset with everything else, so a fresh period after reset runs at
  //       duty 0 instead of driving stale values onto the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_duty <= '0;
      active_duty  <= '0;
      pwm_out      <= 1'b0;
    end else begin
      if (wr) begin
        pending_duty <= wr_data;
      end
      // A write on the load cycle bypasses the pending register.
      // Without the bypass that write would wait a whole extra period.
      if (load) begin
        active_duty <= wr ? wr_data : pending_duty;
      end
      pwm_out <= en_out & (~en_pwm | pwm_raw);
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// ----------------------------------------------------------------------------
// pwm_multichannel
// NUM_CH independent PWM outputs. They share a prescaler and a period counter.
// Duty updates are double-buffered and take effect at a period boundary.
//
// Optional feature: define PWM_CENTER_ALIGNED_EN to add the align_center input.
// With align_center=1 the counter runs up 0..MAX, then down MAX-1..1, giving a
// period of 2*MAX ticks. The mode is latched at each period boundary.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en_out        per-channel output enable (0 -> output low)
//   en_pwm        per-channel PWM enable (0 with en_out=1 -> output high)
//   prescale      one counter step every prescale+1 clk cycles
//   duty_wr       single-cycle duty write strobe
//   duty_ch       channel index for the write; indices >= NUM_CH are ignored
//   duty_data     duty value
//   align_center  (PWM_CENTER_ALIGNED_EN only) center-aligned mode select
//   pwm_out       registered channel outputs
//   period_start  one-cycle pulse, high while cnt is 0 after a period load
// ----------------------------------------------------------------------------
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter  int NUM_CH  = PWM_NUM_CH,
  parameter  int CNT_W   = PWM_CNT_W,
  parameter  int PRESC_W = PWM_PRESC_W,
  localparam int CH_W    = sel_w(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  en_out,
  input  logic [NUM_CH-1:0]  en_pwm,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               duty_wr,
  input  logic [CH_W-1:0]    duty_ch,
  input  logic [CNT_W-1:0]   duty_data,
`ifdef PWM_CENTER_ALIGNED_EN
  input  logic               align_center,
`endif
  output logic [NUM_CH-1:0]  pwm_out,
  output logic               period_start
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               wrap;
  logic               started;
  logic               load;

  // ---------------------------------------------------------------------------
  // Prescaler. The counter wraps on >= rather than ==. If prescale is lowered
  // below the current count, the tick comes on the next cycle instead of after
  // a full counter roll-over.
  // ---------------------------------------------------------------------------
  assign tick = (presc_cnt >= prescale);

  // NOTE: state updates use <= so every flop samples the pre-edge values of
  //       its neighbours, whatever order the blocks are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter: next value and wrap detection.
  // ---------------------------------------------------------------------------
`ifdef PWM_CENTER_ALIGNED_EN
  cnt_dir_e dir;
  cnt_dir_e dir_nxt;
  logic     center_act;   // mode of the current period, latched at load

  // NOTE: every output gets its default before any branch. That way no path
  //       leaves a value unassigned, and no latch is inferred.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    dir_nxt = dir;
    wrap    = 1'b0;
    if (center_act) begin
      if (dir == CNT_UP) begin
        if (cnt == CNT_MAX) begin
          cnt_nxt = CNT_LAST;
          dir_nxt = CNT_DOWN;
        end
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
        // The down-count stops at 1. The next tick goes back to 0 through
        // the load path, which also restores the up direction.
        wrap    = (cnt == CNT_W'(1));
      end
    end else begin
      wrap = (cnt == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir        <= CNT_UP;
      center_act <= 1'b0;
    end else if (load) begin
      dir        <= CNT_UP;
      center_act <= align_center;
    end else if (tick) begin
      dir        <= dir_nxt;
    end
  end
`else
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    wrap    = (cnt == CNT_LAST);
  end
`endif

  // The very first tick after reset opens a period, even though cnt is
  // already 0. It loads the (reset) duty values and pulses period_start.
  assign load = tick && (wrap || !started);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      started      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= load;
      if (load) begin
        cnt     <= '0;
        started <= 1'b1;
      end else if (tick) begin
        cnt     <= cnt_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channels. The write decode compares against each in-range index only,
  // so an out-of-range duty_ch matches no channel.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = duty_wr && (duty_ch == CH_W'(i));

    pwm_channel #(
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt),
      .load    (load),
      .wr      (ch_wr),
      .wr_data (duty_data),
      .en_out  (en_out[i]),
      .en_pwm  (en_pwm[i]),
      .pwm_out (pwm_out[i])
    );
  end

endmodule
